// File: rtl/rj_serial_loader_pkg.sv
// Shared constants and state encoding for the Rj, coefficient and data loaders.
package rj_serial_loader_pkg;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 16;
    localparam int ADDR_W    = 4;
    localparam int CNT_W     = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        SHIFT      = 2'd2,
        DONE       = 2'd3
    } state_t;

endpackage

// File: rtl/rj_serial_loader_shifter.sv
// MSB-first deserialiser: start loads the MSB, shift appends bits.
// word_valid flags the cycle whose bit_in completes the word.
module serial_word_shifter
    import rj_serial_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              shift,
    input  logic              bit_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    // The final bit is taken straight from bit_in, so only WORD_W-1 bits are stored.
    logic [WORD_W-2:0] sr;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (start) begin
            sr  <= {{(WORD_W-2){1'b0}}, bit_in};
            cnt <= CNT_W'(1);
        end else if (shift) begin
            sr  <= {sr[WORD_W-3:0], bit_in};
            cnt <= cnt + 1'b1;
        end
    end

    assign word       = {sr, bit_in};
    assign word_valid = shift && (cnt == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/rj_serial_loader.sv
// Serial front end for the Rj memory: frames serial words and writes
// NUM_WORDS of them at incrementing addresses, then reports done.
module rj_serial_loader
    import rj_serial_loader_pkg::*;
(
    input  logic              Sclk,
    input  logic              Reset,
    input  logic              load_start,
    input  logic              Frame,
    input  logic              InputL,
    output logic [WORD_W-1:0] data_out,
    output logic              write_enable,
    output logic              wr_frame,
    output logic [ADDR_W-1:0] Write_Address,
    output logic              rj_done,
    output logic              frame_err
);

    state_t            state;
    logic [ADDR_W-1:0] word_cnt;
    logic              start;
    logic              shift_en;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    // A Frame during SHIFT truncates the word and restarts from this bit.
    assign start    = Frame && ((state == WAIT_FRAME) || (state == SHIFT));
    assign shift_en = (state == SHIFT) && !Frame;

    serial_word_shifter u_shifter (
        .clk        (Sclk),
        .rst        (Reset),
        .start      (start),
        .shift      (shift_en),
        .bit_in     (InputL),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge Sclk) begin
        if (Reset) begin
            state         <= IDLE;
            word_cnt      <= '0;
            data_out      <= '0;
            write_enable  <= 1'b0;
            wr_frame      <= 1'b0;
            Write_Address <= '0;
            rj_done       <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            wr_frame     <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= WAIT_FRAME;
                        word_cnt  <= '0;
                        frame_err <= 1'b0;
                    end
                end
                WAIT_FRAME: begin
                    if (Frame) state <= SHIFT;
                end
                SHIFT: begin
                    if (Frame) begin
                        frame_err <= 1'b1;
                    end else if (word_valid) begin
                        // Strobe lands in the cycle a back-to-back Frame may arrive.
                        write_enable  <= 1'b1;
                        wr_frame      <= 1'b1;
                        data_out      <= word;
                        Write_Address <= word_cnt;
                        word_cnt      <= word_cnt + 1'b1;
                        if (word_cnt == ADDR_W'(NUM_WORDS - 1)) state <= DONE;
                        else state <= WAIT_FRAME;
                    end
                end
                DONE: begin
                    if (load_start) begin
                        state     <= WAIT_FRAME;
                        word_cnt  <= '0;
                        rj_done   <= 1'b0;
                        frame_err <= 1'b0;
                    end else begin
                        rj_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rj_serial_loader.sv
// Bench for rj_serial_loader: random serial words against a word-level
// scoreboard of expected memory writes.
module tb_rj_serial_loader;
    import rj_serial_loader_pkg::*;

    logic        Sclk = 1'b0;
    logic        Reset = 1'b1;
    logic        load_start = 1'b0;
    logic        Frame = 1'b0;
    logic        InputL = 1'b0;
    logic [15:0] data_out;
    logic        write_enable;
    logic        wr_frame;
    logic [3:0]  Write_Address;
    logic        rj_done;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];
    int          m_addr;
    bit          m_active;
    bit          m_done;

    always #5 Sclk = ~Sclk;

    rj_serial_loader dut (
        .Sclk          (Sclk),
        .Reset         (Reset),
        .load_start    (load_start),
        .Frame         (Frame),
        .InputL        (InputL),
        .data_out      (data_out),
        .write_enable  (write_enable),
        .wr_frame      (wr_frame),
        .Write_Address (Write_Address),
        .rj_done       (rj_done),
        .frame_err     (frame_err)
    );

    always @(posedge Sclk) begin
        #1;
        if (write_enable) got_q.push_back({Write_Address, data_out});
    end

    // Reference: a load accepts NUM_WORDS complete words at addresses 0,1,2,...
    function automatic void m_reset();
        m_active = 0;
        m_done   = 0;
        m_addr   = 0;
    endfunction

    function automatic void m_load();
        m_active = 1;
        m_done   = 0;
        m_addr   = 0;
    endfunction

    function automatic void m_word(input logic [15:0] w);
        if (m_active && !m_done) begin
            exp_q.push_back({4'(m_addr), w});
            m_addr = m_addr + 1;
            if (m_addr == NUM_WORDS) begin
                m_done = 1;
                m_addr = 0;
            end
        end
    endfunction

    function automatic int q_diff();
        int n = 0;
        if (got_q.size() != exp_q.size()) return 99;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic tick();
        @(negedge Sclk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Frame = 1'b0;
        load_start = 1'b0;
        tick();
        Reset = 1'b0;
        m_reset();
        tick();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        m_load();
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            Frame  = (i == 15);
            InputL = w[i];
            tick();
        end
        Frame  = 1'b0;
        InputL = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data got %h need 0000", data_out); end
        if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b need 0", write_enable); end
        if (wr_frame !== 1'b0) begin errors++; $display("FAIL reset_wrf got %b need 0", wr_frame); end
        if (Write_Address !== 4'h0) begin errors++; $display("FAIL reset_addr got %h need 0", Write_Address); end
        if (rj_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b need 0", rj_done); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b need 0", frame_err); end
    endtask

    task automatic test_idle_ignore();
        int d;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] w = 16'($urandom);
            send_word(w);
            m_word(w);
            checks++;
            if (write_enable !== 1'b0) begin errors++; $display("FAIL idle_we got %b need 0", write_enable); end
        end
        tick();
        d = q_diff();
        checks++;
        if (d != 0) begin errors++; $display("FAIL idle_writes got %0d writes need %0d", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_contiguous();
        int d;
        do_reset();
        do_load();
        for (int k = 1; k <= 16; k++) begin
            send_word(16'(k));
            m_word(16'(k));
            checks++;
            if (write_enable !== 1'b1 || wr_frame !== 1'b1 || data_out !== 16'(k) ||
                Write_Address !== 4'(k - 1)) begin
                errors++;
                $display("FAIL contig_word%0d got we=%b wf=%b d=%h a=%h need we=1 wf=1 d=%h a=%h",
                         k, write_enable, wr_frame, data_out, Write_Address, 16'(k), 4'(k - 1));
            end
        end
        checks++;
        if (rj_done !== 1'b0) begin errors++; $display("FAIL contig_done_early got %b need 0", rj_done); end
        tick();
        checks++;
        if (rj_done !== 1'b1 || write_enable !== 1'b0) begin
            errors++;
            $display("FAIL contig_done got done=%b we=%b need done=1 we=0", rj_done, write_enable);
        end
        tick();
        d = q_diff();
        checks++;
        if (d != 0) begin errors++; $display("FAIL contig_writes got %0d writes need %0d (%0d bad)", got_q.size(), exp_q.size(), d); end
    endtask

    task automatic test_after_done();
        int d;
        got_q.delete();
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] w = 16'($urandom);
            send_word(w);
            m_word(w);
            checks++;
            if (write_enable !== 1'b0 || rj_done !== 1'b1) begin
                errors++;
                $display("FAIL done_ignore got we=%b done=%b need we=0 done=1", write_enable, rj_done);
            end
        end
        do_load();
        checks++;
        if (rj_done !== 1'b0) begin errors++; $display("FAIL reload_done got %b need 0", rj_done); end
        send_word(16'hA5A5);
        m_word(16'hA5A5);
        checks++;
        if (write_enable !== 1'b1 || data_out !== 16'hA5A5 || Write_Address !== 4'h0 || rj_done !== 1'b0) begin
            errors++;
            $display("FAIL reload_word got we=%b d=%h a=%h done=%b need we=1 d=a5a5 a=0 done=0",
                     write_enable, data_out, Write_Address, rj_done);
        end
        tick();
        d = q_diff();
        checks++;
        if (d != 0) begin errors++; $display("FAIL done_writes got %0d writes need %0d", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_gaps();
        int d;
        int bad;
        do_reset();
        do_load();
        for (int k = 0; k < 4; k++) begin
            logic [15:0] w = 16'($urandom);
            send_word(w);
            m_word(w);
            checks++;
            if (write_enable !== 1'b1 || data_out !== w || Write_Address !== 4'(k)) begin
                errors++;
                $display("FAIL gap_word%0d got we=%b d=%h a=%h need we=1 d=%h a=%h",
                         k, write_enable, data_out, Write_Address, w, 4'(k));
            end
            bad = 0;
            for (int g = 0; g < 5; g++) begin
                InputL = 1'($urandom);
                tick();
                if (write_enable !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL gap_strobe got %0d strobes need 0", bad); end
        end
        d = q_diff();
        checks++;
        if (d != 0) begin errors++; $display("FAIL gap_writes got %0d writes need %0d (%0d bad)", got_q.size(), exp_q.size(), d); end
    endtask

    task automatic test_early_frame();
        int d;
        do_reset();
        do_load();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] w = 16'($urandom);
            send_word(w);
            m_word(w);
        end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL early_ferr_pre got %b need 0", frame_err); end
        for (int i = 0; i < 7; i++) begin
            Frame  = (i == 0);
            InputL = 1'($urandom);
            tick();
        end
        send_word(16'hBEEF);
        m_word(16'hBEEF);
        checks++;
        if (write_enable !== 1'b1 || data_out !== 16'hBEEF || Write_Address !== 4'h3 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL early_word got we=%b d=%h a=%h ferr=%b need we=1 d=beef a=3 ferr=1",
                     write_enable, data_out, Write_Address, frame_err);
        end
        tick();
        d = q_diff();
        checks++;
        if (d != 0) begin errors++; $display("FAIL early_writes got %0d writes need %0d (%0d bad)", got_q.size(), exp_q.size(), d); end
    endtask

    task automatic test_reset_mid();
        int d;
        logic [15:0] w;
        do_reset();
        do_load();
        for (int k = 0; k < 5; k++) begin
            w = 16'($urandom);
            send_word(w);
            m_word(w);
        end
        for (int i = 0; i < 9; i++) begin
            Frame  = (i == 0);
            InputL = 1'($urandom);
            tick();
        end
        Frame = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        m_reset();
        checks++;
        if (data_out !== 16'h0 || write_enable !== 1'b0 || wr_frame !== 1'b0 ||
            Write_Address !== 4'h0 || rj_done !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outs got d=%h we=%b wf=%b a=%h done=%b ferr=%b need all 0",
                     data_out, write_enable, wr_frame, Write_Address, rj_done, frame_err);
        end
        w = 16'($urandom);
        send_word(w);
        m_word(w);
        checks++;
        if (write_enable !== 1'b0) begin errors++; $display("FAIL midreset_idle got we=%b need 0", write_enable); end
        do_load();
        w = 16'($urandom);
        send_word(w);
        m_word(w);
        checks++;
        if (write_enable !== 1'b1 || data_out !== w || Write_Address !== 4'h0) begin
            errors++;
            $display("FAIL midreset_reload got we=%b d=%h a=%h need we=1 d=%h a=0",
                     write_enable, data_out, Write_Address, w);
        end
        tick();
        d = q_diff();
        checks++;
        if (d != 0) begin errors++; $display("FAIL midreset_writes got %0d writes need %0d (%0d bad)", got_q.size(), exp_q.size(), d); end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_idle_ignore();
        test_contiguous();
        test_after_done();
        test_gaps();
        test_early_frame();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
